m_mux_n_pipe: RTL and testbench

//  Parametrised N:1 data-path selector with a registered, valid/ready-handshaked output stage.

---
 rtl/mux_pkg.sv | 12 +
 rtl/m_skid_buf.sv | 78 +++++++
 rtl/m_mux_n_pipe.sv | 76 +++++++
 tb/tb_m_mux_n_pipe.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared defaults and occupancy encoding for the N:1 select-and-retime block.
package mux_pkg;
  localparam int MUX_WIDTH = 32;
  localparam int MUX_N_IN  = 3;
  localparam int MUX_CNT_W = 8;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;
endpackage

// File: rtl/m_skid_buf.sv
// 2-entry skid buffer: one cycle from accept to output valid, and in_ready is a flop.
// in_ready never depends combinationally on out_ready, so a full buffer always absorbs one stall.
module m_skid_buf
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  occ_t             occ;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic             rdy_q;
  logic             vld_q;
  logic             push;
  logic             pop;

  assign push      = in_valid && rdy_q;
  assign pop       = vld_q && out_ready;
  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_data  = head_q;

  // head_q is always the oldest entry; tail_q is only live in OCC_FULL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ    <= OCC_EMPTY;
      head_q <= '0;
      tail_q <= '0;
      rdy_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          rdy_q <= 1'b1;
          if (push) begin
            head_q <= in_data;
            occ    <= OCC_ONE;
            vld_q  <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head_q <= in_data;
          end else if (push) begin
            tail_q <= in_data;
            occ    <= OCC_FULL;
            rdy_q  <= 1'b0;
          end else if (pop) begin
            occ   <= OCC_EMPTY;
            vld_q <= 1'b0;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            head_q <= tail_q;
            occ    <= OCC_ONE;
            rdy_q  <= 1'b1;
          end
        end
        default: begin
          occ   <= OCC_EMPTY;
          rdy_q <= 1'b1;
          vld_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/m_mux_n_pipe.sv
// N:1 select retimed through a skid buffer (1-cycle latency, registered in_ready under stall).
// Out-of-range selects resolve to d[0] and raise a sticky flag plus a saturating counter.
module m_mux_n_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH,
  parameter int N_IN  = MUX_N_IN,
  parameter int SEL_W = ($clog2(N_IN) > 1) ? $clog2(N_IN) : 1,
  parameter int CNT_W = MUX_CNT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_IN-1:0][WIDTH-1:0] d,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       err_clr,
  output logic                       err_flag,
  output logic [CNT_W-1:0]           err_cnt
);

  logic [WIDTH-1:0] sel_dat;
  logic             sel_err;
  logic             accept;

  always_comb begin
    sel_dat = d[0];
    sel_err = 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_dat = d[i];
        sel_err = 1'b0;
      end
    end
  end

  assign accept = in_valid && in_ready;

  m_skid_buf #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_data  (sel_dat),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // A fresh error in the clearing cycle wins over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end else if (accept && sel_err) begin
      err_flag <= 1'b1;
      if (err_clr) begin
        err_cnt <= CNT_W'(1);
      end else if (err_cnt != {CNT_W{1'b1}}) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end else if (err_clr) begin
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end
  end

  sel_known_a: assert property (@(posedge clk) disable iff (reset)
    in_valid |-> !$isunknown(sel));

endmodule

// File: tb/tb_m_mux_n_pipe.sv
module tb_m_mux_n_pipe;
  logic             clk;
  logic             reset;
  logic [2:0][31:0] d;
  logic [1:0]       sel;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic             err_clr;
  logic             err_flag;
  logic [7:0]       err_cnt;

  int total = 0;
  int bad   = 0;

  m_mux_n_pipe #(.WIDTH(32), .N_IN(3), .CNT_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .d        (d),
    .sel      (sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_clr  (err_clr),
    .err_flag (err_flag),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; d = '0; sel = '0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_err_flag",  32'(err_flag),  32'd0);
    chk("rst_err_cnt",   32'(err_cnt),   32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // back-to-back A,B,C with a free-flowing sink
    d[0] = 32'hA; d[1] = 32'hB; d[2] = 32'hC;
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd0;
    tick();
    chk("bb_vld_a", 32'(out_valid), 32'd1);
    chk("bb_dat_a", out_data, 32'hA);
    sel = 2'd1;
    tick();
    chk("bb_dat_b", out_data, 32'hB);
    sel = 2'd2;
    tick();
    chk("bb_dat_c", out_data, 32'hC);
    chk("bb_vld_c", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bb_drain_vld", 32'(out_valid), 32'd0);
    chk("bb_err_flag",  32'(err_flag),  32'd0);

    // stall: fill both entries, third word held off
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0; d[0] = 32'h11;
    tick();
    chk("st_rdy_1", 32'(in_ready), 32'd1);
    chk("st_dat_1", out_data, 32'h11);
    d[0] = 32'h22;
    tick();
    chk("st_rdy_2", 32'(in_ready), 32'd0);
    chk("st_dat_2", out_data, 32'h11);
    d[0] = 32'h33;
    tick();
    chk("st_rdy_3", 32'(in_ready), 32'd0);
    chk("st_hold",  out_data, 32'h11);
    out_ready = 1'b1;
    tick();
    chk("st_pop1_dat", out_data, 32'h22);
    chk("st_pop1_rdy", 32'(in_ready), 32'd1);
    tick();
    chk("st_pop2_dat", out_data, 32'h33);
    in_valid = 1'b0;
    tick();
    chk("st_empty", 32'(out_valid), 32'd0);

    // out-of-range select falls back to d[0]; counter saturates
    d[0] = 32'h1234; sel = 2'd3; in_valid = 1'b1;
    tick();
    chk("oor_dat",  out_data, 32'h1234);
    chk("oor_flag", 32'(err_flag), 32'd1);
    chk("oor_cnt",  32'(err_cnt),  32'd1);
    repeat (299) @(posedge clk);
    #1;
    chk("oor_sat", 32'(err_cnt), 32'd255);

    // clear coinciding with an error: error wins
    err_clr = 1'b1;
    tick();
    chk("clr_err_flag", 32'(err_flag), 32'd1);
    chk("clr_err_cnt",  32'(err_cnt),  32'd1);
    in_valid = 1'b0;
    tick();
    chk("clr_flag", 32'(err_flag), 32'd0);
    chk("clr_cnt",  32'(err_cnt),  32'd0);
    err_clr = 1'b0;
    tick();

    // rejected erroring selects must not count
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0; d[0] = 32'h55;
    tick(); tick();
    chk("rej_full", 32'(in_ready), 32'd0);
    sel = 2'd3;
    tick(); tick(); tick();
    chk("rej_cnt_held",  32'(err_cnt),  32'd0);
    chk("rej_flag_held", 32'(err_flag), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("rej_cnt_pop", 32'(err_cnt), 32'd0);
    tick();
    chk("rej_cnt_acc", 32'(err_cnt), 32'd1);

    // mid-stream reset with both entries occupied
    out_ready = 1'b0; sel = 2'd0; d[0] = 32'h77;
    tick(); tick();
    chk("mrst_pre_rdy", 32'(in_ready),  32'd0);
    chk("mrst_pre_vld", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("mrst_vld", 32'(out_valid), 32'd0);
    chk("mrst_rdy", 32'(in_ready),  32'd0);
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("mrst_rel_rdy", 32'(in_ready),  32'd1);
    chk("mrst_rel_cnt", 32'(err_cnt),   32'd0);
    chk("mrst_rel_vld", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
